// File: rtl/cdc_sync_bus.sv
// cdc_sync_bus: multi-channel single-bit CDC synchroniser with per-channel
// edge pulses. Each channel passes through a STAGES-deep flop chain. An
// optional stability filter follows the chain when CDC_SYNC_FILT_EN is
// defined. Without the macro, q is taken straight from the last chain flop.
// Provides no multi-bit coherence; coherent buses need Gray code or a handshake.
module cdc_sync_bus #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      STAGES      = 2,
  parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}},
  parameter int unsigned      FILT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Parameter legality is enforced at elaboration.
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("cdc_sync_bus: STAGES must be in 2..4");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("cdc_sync_bus: WIDTH must be >= 1");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("cdc_sync_bus: FILT_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] s [STAGES];
  logic [WIDTH-1:0] sl;
  logic [WIDTH-1:0] q_prev;

  // First synchroniser stage captures the asynchronous inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) s[0] <= RST_VAL;
    else        s[0] <= d;
  end

  for (genvar k = 1; k < STAGES; k++) begin : g_chain
    // Remaining stages are plain flop-to-flop with no logic in between.
    always_ff @(posedge clk) begin
      if (!rst_n) s[k] <= RST_VAL;
      else        s[k] <= s[k-1];
    end
  end

  assign sl = s[STAGES-1];

`ifdef CDC_SYNC_FILT_EN
  localparam int unsigned CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [WIDTH-1:0] q_filt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_filt
    logic [CW-1:0] cnt;

    // q follows sl only after sl has differed from q for FILT_CYCLES edges.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt       <= '0;
        q_filt[i] <= RST_VAL[i];
      end else if (sl[i] == q_filt[i]) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt       <= '0;
        q_filt[i] <= sl[i];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign q = q_filt;
`else
  assign q = sl;
`endif

  // History of q for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) q_prev <= RST_VAL;
    else        q_prev <= q;
  end

  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;

endmodule

// File: tb/tb_cdc_sync_bus.sv
// Self-checking bench for cdc_sync_bus (WIDTH=4, RST_VAL=4'b1010). It works
// with or without CDC_SYNC_FILT_EN. The reference model is a sample-history
// view of the behaviour: a delay line of d samples, plus a window of recent
// synchronised values that must all disagree with q before q flips.
module tb_cdc_sync_bus;

  localparam int unsigned W    = 4;
  localparam int unsigned STG  = 2;
  localparam int unsigned FILT = 4;
  localparam logic [W-1:0] RSTV = 4'b1010;
`ifdef CDC_SYNC_FILT_EN
  localparam int LAT = STG + FILT;
`else
  localparam int LAT = STG;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] d;
  logic [W-1:0] q, rise, fall;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [W-1:0] dline[$];
  logic [W-1:0] slhist[$];
  logic [W-1:0] qm, qpm;

  cdc_sync_bus #(
    .WIDTH(W), .STAGES(STG), .RST_VAL(RSTV), .FILT_CYCLES(FILT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .q(q), .rise(rise), .fall(fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge, given the inputs sampled at that edge.
  function automatic void model_edge(input logic [W-1:0] dv, input logic rv);
    logic [W-1:0] sl_old, q_old;
    bit all_diff;
    if (!rv) begin
      dline = {};
      repeat (STG) dline.push_back(RSTV);
      slhist = {};
      qm  = RSTV;
      qpm = RSTV;
      return;
    end
    sl_old = dline[STG-1];
    q_old  = qm;
    qpm    = q_old;
    dline.push_front(dv);
    void'(dline.pop_back());
`ifdef CDC_SYNC_FILT_EN
    slhist.push_back(sl_old);
    if (slhist.size() > FILT) void'(slhist.pop_front());
    for (int i = 0; i < int'(W); i++) begin
      all_diff = (slhist.size() == FILT);
      foreach (slhist[j]) if (slhist[j][i] == q_old[i]) all_diff = 0;
      if (all_diff) qm[i] = ~q_old[i];
    end
`else
    all_diff = 0;
    qm = dline[STG-1];
`endif
  endfunction

  // One clock: drive, clock, sample 1 time unit later, compare with the model.
  task automatic step(input logic [W-1:0] dv, input logic rv);
    d = dv;
    rst_n = rv;
    @(posedge clk);
    #1;
    model_edge(dv, rv);
    chk("model_q", q, qm);
    chk("model_rise", rise, qm & ~qpm);
    chk("model_fall", fall, ~qm & qpm);
  endtask

  task automatic settle(input logic [W-1:0] dv);
    repeat (LAT + 6) step(dv, 1'b1);
  endtask

  // Count edges until q[b] reaches target (bounded).
  task automatic measure(input logic [W-1:0] dv, input int b, input logic target, output int edges);
    edges = -1;
    for (int n = 1; n <= 30 && edges < 0; n++) begin
      step(dv, 1'b1);
      if (q[b] === target) edges = n;
    end
  endtask

  initial begin
    int edges, highs, rises, falls, hold;
    logic [W-1:0] dv;
    logic rv;

    // Reset held for 3 cycles with d opposite to RST_VAL.
    d = 4'b0101;
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step(4'b0101, 1'b0);
      chk("rst_q", q, RSTV);
      chk("rst_rise", rise, 4'b0000);
      chk("rst_fall", fall, 4'b0000);
    end
    for (int n = 1; n <= LAT + 1; n++) begin
      step(4'b0101, 1'b1);
      if (n == LAT - 1) chk("rel_q_before", q, RSTV);
      if (n == LAT) begin
        chk("rel_q", q, 4'b0101);
        chk("rel_rise", rise, 4'b0101);
        chk("rel_fall", fall, 4'b1010);
      end
      if (n == LAT + 1) begin
        chk("rel_rise_once", rise, 4'b0000);
        chk("rel_fall_once", fall, 4'b0000);
      end
    end

    // Latency of a clean 0->1 on channel 0.
    settle(4'b1010);
    measure(4'b1011, 0, 1'b1, edges);
    chk_int("latency_rise", edges, LAT);
    chk("latency_rise_pulse", rise, 4'b0001);

    // Glitch rejection on channel 1: 3-cycle pulse, then 4-cycle pulse.
    settle(4'b1000);
    for (int p = 3; p <= 4; p++) begin
      highs = 0; rises = 0; falls = 0;
      for (int n = 0; n < p + LAT + 8; n++) begin
        step((n < p) ? 4'b1010 : 4'b1000, 1'b1);
        highs += int'(q[1]);
        rises += int'(rise[1]);
        falls += int'(fall[1]);
      end
`ifdef CDC_SYNC_FILT_EN
      chk_int($sformatf("pulse%0d_highs", p), highs, (p >= int'(FILT)) ? p : 0);
      chk_int($sformatf("pulse%0d_rises", p), rises, (p >= int'(FILT)) ? 1 : 0);
      chk_int($sformatf("pulse%0d_falls", p), falls, (p >= int'(FILT)) ? 1 : 0);
`else
      chk_int($sformatf("pulse%0d_highs", p), highs, p);
      chk_int($sformatf("pulse%0d_rises", p), rises, 1);
      chk_int($sformatf("pulse%0d_falls", p), falls, 1);
`endif
    end

    // Independence: all rise together, channel 2 drops after 2 cycles.
    settle(4'b0000);
    for (int n = 1; n <= LAT + 6; n++) begin
      step((n <= 2) ? 4'b1111 : 4'b1011, 1'b1);
      if (n == LAT - 1) chk("indep_before", q & 4'b1011, 4'b0000);
      if (n == LAT) chk("indep_at", q & 4'b1011, 4'b1011);
    end

    // Mid-operation reset discards a pending 1->0 on channel 3.
    settle(4'b1010);
    for (int n = 1; n <= 3; n++) step(4'b0010, 1'b1);
    step(4'b0010, 1'b0);
    chk("midrst_q", q, RSTV);
    chk("midrst_fall", fall, 4'b0000);
    measure(4'b0010, 3, 1'b0, edges);
    chk_int("midrst_relatency", edges, LAT);
    chk("midrst_fall_pulse", fall & 4'b1000, 4'b1000);

    // Randomised bursts with occasional resets.
    for (int b = 0; b < 60; b++) begin
      dv   = W'($urandom);
      hold = int'($urandom_range(1, 7));
      rv   = ($urandom_range(0, 24) != 0);
      if (!rv) step(dv, 1'b0);
      else repeat (hold) step(dv, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound in case something stalls.
  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cdc_sync_bus.md
Name: cdc_sync_bus

Overview:
- Parametrised multi-channel CDC synchroniser, successor to the single-bit 2-FF synchroniser.
- Each of WIDTH independent single-bit channels passes through a STAGES-deep flop chain.
- An optional per-channel stability filter follows the chain, then registered edge detection produces one-cycle rise/fall pulses.
- Used for async control/status levels (IRQ lines, enables, external strobes) entering the clk domain. It does not give multi-bit coherence; buses needing that use Gray coding or a handshake.

Parameters:
- WIDTH, 1, number of independent channels (>=1).
- STAGES, 2, synchroniser flop depth per channel (legal 2..4; elaboration error outside this range).
- RST_VAL, {WIDTH{1'b0}}, per-channel reset value of the chain, q, and the edge history.
- FILT_CYCLES, 4, consecutive cycles a new synchronised value must persist before q updates (>=1; used only when the filter is compiled in).

Ports:
- clk  input  1  destination-domain clock.
- rst_n  input  1  reset, synchronous to clk, active-low.
- d  input  WIDTH  asynchronous inputs, one per channel.
- q  output  WIDTH  synchronised (and filtered) level.
- rise  output  WIDTH  one-cycle pulse in the first cycle q[i] reads 1 after reading 0.
- fall  output  WIDTH  one-cycle pulse in the first cycle q[i] reads 0 after reading 1.

Behaviour:
- Single clock, synchronous active-low reset. When rst_n=0 at a clk edge, all state loads reset values: chain flops s[k]=RST_VAL, filter counters=0, q=RST_VAL, q_prev=RST_VAL. Consequently rise=fall=0 during and immediately after reset.
- Chain: at each edge, s[0]<=d and s[k]<=s[k-1]. Let sl=s[STAGES-1]. No logic is placed between chain flops.
- Filter (per channel, compiled in):
  - q is a register, and the counter is $clog2(FILT_CYCLES+1) bits wide.
  - If sl[i]==q[i], the counter clears to 0.
  - Otherwise, if counter==FILT_CYCLES-1, then q[i]<=sl[i] and the counter clears to 0.
  - Otherwise the counter increments.
  - Any return of sl to q's value before the threshold discards the partial count, so pulses shorter than FILT_CYCLES cycles at sl are rejected.
- Latency:
  - A clean d transition first sampled at edge E1 appears on q after edge E(STAGES+FILT_CYCLES). With defaults that is edge 6.
  - Without the filter, q is sl, so latency is STAGES edges.
- Edge detect: q_prev<=q every cycle. rise=q&~q_prev and fall=~q&q_prev, both combinational from registers, giving exactly one cycle per q transition.
- Channels are fully independent. Simultaneous transitions on several channels are handled per channel, with no cross-channel ordering guarantee.
- Reset mid-operation: an in-progress filter count is discarded and any pending transition is lost. After reset release, q follows d within the normal latency. If d differs from RST_VAL at release, exactly one edge pulse is produced when q updates.
- The counter never exceeds FILT_CYCLES-1 and never wraps.
- d may change at any time. A value that is metastable or changes during the sampling window resolves in s[0]. Either old or new value is acceptable, but q must never glitch mid-cycle.

Optional Feature:
- Macro CDC_SYNC_FILT_EN.
- Defined: the stability filter is present as described, and q is a filter register.
- Undefined: no counters or filter registers are instantiated. FILT_CYCLES is ignored, q=sl directly, latency is STAGES edges, and rise/fall derive from sl and q_prev.

Test Plan:
1. Reset: WIDTH=4, RST_VAL=4'b1010, hold rst_n=0 for 3 cycles with d=4'b0101, then release -> q=4'b1010 during reset, with no rise/fall. With the filter, q=4'b0101 at edge 6 after release, rise=4'b0101 and fall=4'b1010 for exactly one cycle.
2. Latency: defaults with filter, d[0] 0->1 before edge 1 -> q[0] rises at edge 6, with rise[0] high only in the cycle after edge 6. Without the macro -> q[0] rises at edge 2.
3. Glitch reject: filter on, d[1] high for 3 cycles then low -> q[1] stays 0, rise[1] never asserts, and the counter returns to 0. A 4-cycle pulse -> q[1] high for 4 cycles, with one rise and one fall pulse.
4. Independence: d=4'b0000->4'b1111 on one edge, then d[2] drops 2 cycles later -> q[0,1,3] update at edge 6. q[2] does not update if its high time is shorter than the filter threshold, otherwise it follows its own timing.
5. Mid-operation reset: start a d[3] transition, assert rst_n=0 at edge 4 -> counter cleared, q[3]=RST_VAL[3], no pulse. After release, the transition re-qualifies with full latency.
6. Parameter sweep: STAGES=3,4 and FILT_CYCLES=1 -> latency equals STAGES+1 edges. STAGES=1 -> elaboration error.
